// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits (one outstanding producer each) plus a sticky protocol-error flag.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 i_iss,
  input  logic [AW-1:0]        i_iss_wn,
  input  logic                 i_wea,
  input  logic [AW-1:0]        i_wna,
  input  logic                 i_web,
  input  logic [AW-1:0]        i_wnb,
  output logic [(1<<AW)-1:0]   o_busy,
  output logic                 o_err
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] r_busy;
  logic             r_err;
  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_iss_hit;
  logic             w_err_set;

  // Register 0 never appears in either hit vector, so its busy bit stays 0.
  always_comb begin
    w_wr_hit  = '0;
    w_iss_hit = '0;
    if (i_wea && i_wna != '0)    w_wr_hit[i_wna]     = 1'b1;
    if (i_web && i_wnb != '0)    w_wr_hit[i_wnb]     = 1'b1;
    if (i_iss && i_iss_wn != '0) w_iss_hit[i_iss_wn] = 1'b1;
  end

  assign w_err_set = (|(w_iss_hit & r_busy & ~w_wr_hit)) | (|(w_wr_hit & ~r_busy));

  // Issue wins over a same-cycle write: the new producer owns the register.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_wr_hit) | w_iss_hit;
      r_err  <= r_err | w_err_set;
    end
  end

  assign o_busy = r_busy;
  assign o_err  = r_err;
endmodule

// File: rtl/regfile_mp_sb.sv
// NR-read / 2-write register file, reg 0 hardwired to zero, with issue scoreboard.
// Same-cycle write forwarding to the read ports is enabled by defining RF_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NR*AW-1:0]   rn,
  output logic [NR*DW-1:0]   q,
  output logic [NR-1:0]      rbusy,
  input  logic               wea,
  input  logic [AW-1:0]      wna,
  input  logic [DW-1:0]      da,
  input  logic               web,
  input  logic [AW-1:0]      wnb,
  input  logic [DW-1:0]      db,
  input  logic               iss,
  input  logic [AW-1:0]      iss_wn,
  output logic               err
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [DEPTH-1:0]         w_busy;
  logic                     w_wra;
  logic                     w_wrb;

  assign w_wra = wea && (wna != '0);
  assign w_wrb = web && (wnb != '0);

  // Port B has priority when both ports target the same register.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_mem <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (w_wrb && wnb == AW'(r))      r_mem[r] <= db;
        else if (w_wra && wna == AW'(r)) r_mem[r] <= da;
      end
    end
  end

  rf_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .clrn     (clrn),
    .i_iss    (iss),
    .i_iss_wn (iss_wn),
    .i_wea    (wea),
    .i_wna    (wna),
    .i_web    (web),
    .i_wnb    (wnb),
    .o_busy   (w_busy),
    .o_err    (err)
  );

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] w_rn;
    assign w_rn = rn[k*AW +: AW];
`ifdef RF_BYPASS_EN
    logic w_hita;
    logic w_hitb;
    // Gated by reset so q stays 0 while clrn is held.
    assign w_hita = !clrn && w_wra && (wna == w_rn);
    assign w_hitb = !clrn && w_wrb && (wnb == w_rn);
    assign q[k*DW +: DW] = w_hitb ? db : (w_hita ? da : r_mem[w_rn]);
    assign rbusy[k]      = w_busy[w_rn] & ~(w_hita | w_hitb);
`else
    assign q[k*DW +: DW] = r_mem[w_rn];
    assign rbusy[k]      = w_busy[w_rn];
`endif
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed table-driven bench for regfile_mp_sb plus hand sequences for reset corner cases.
module tb_regfile_mp_sb;
  import regfile_pkg::*;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clrn;
  logic [NR*AW-1:0]  rn;
  logic [NR*DW-1:0]  q;
  logic [NR-1:0]     rbusy;
  logic              wea, web, iss;
  logic [AW-1:0]     wna, wnb, iss_wn;
  logic [DW-1:0]     da, db;
  logic              err;

  int n_tot  = 0;
  int n_pass = 0;

  regfile_mp_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk(clk), .clrn(clrn), .rn(rn), .q(q), .rbusy(rbusy),
    .wea(wea), .wna(wna), .da(da), .web(web), .wnb(wnb), .db(db),
    .iss(iss), .iss_wn(iss_wn), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wea;
    reg_idx_t        wna;
    logic [DW-1:0]   da;
    logic            web;
    reg_idx_t        wnb;
    logic [DW-1:0]   db;
    logic            iss;
    reg_idx_t        iss_wn;
    reg_idx_t        rn0, rn1;
    logic [DW-1:0]   eq0, eq1;
    logic [1:0]      ebusy;
    logic            eerr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic a_we, reg_idx_t a_wn, logic [DW-1:0] a_d,
                              logic b_we, reg_idx_t b_wn, logic [DW-1:0] b_d,
                              logic is, reg_idx_t is_wn, reg_idx_t r0, reg_idx_t r1,
                              logic [DW-1:0] e0, logic [DW-1:0] e1, logic [1:0] eb, logic ee);
    vec_t v;
    v.wea = a_we; v.wna = a_wn; v.da = a_d;
    v.web = b_we; v.wnb = b_wn; v.db = b_d;
    v.iss = is;   v.iss_wn = is_wn;
    v.rn0 = r0;   v.rn1 = r1;
    v.eq0 = e0;   v.eq1 = e1; v.ebusy = eb; v.eerr = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic idle();
    wea = 1'b0; wna = ZERO_REG; da = '0;
    web = 1'b0; wnb = ZERO_REG; db = '0;
    iss = 1'b0; iss_wn = ZERO_REG;
  endtask

  task automatic drive(input vec_t v);
    wea = v.wea; wna = v.wna; da = v.da;
    web = v.web; wnb = v.wnb; db = v.db;
    iss = v.iss; iss_wn = v.iss_wn;
    rn  = {v.rn1, v.rn0};
  endtask

  initial begin
    clrn = 1'b1;
    idle();
    rn = '0;

    // Table: outputs observed in the cycle the inputs are applied (before the edge).
    vt.push_back(mk(1,0,32'hFFFF_FFFF, 0,0,0, 0,0,  0,31, 0,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0, 0,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,5,  5,0, 0,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  5,0, 0,0, 2'b01, 0));
    vt.push_back(mk(1,5,32'h1234, 0,0,0, 0,0, 5,5,
                    BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0, BYP ? 2'b00 : 2'b11, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  5,0, 32'h1234,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,7,  7,0, 0,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,8,  7,8, 0,0, 2'b01, 0));
    vt.push_back(mk(1,7,32'hA, 1,8,32'hB, 0,0, 7,8,
                    BYP ? 32'hA : 32'h0, BYP ? 32'hB : 32'h0, BYP ? 2'b00 : 2'b11, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  7,8, 32'hA,32'hB, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,9,  0,0, 0,0, 2'b00, 0));
    vt.push_back(mk(1,9,32'h1, 1,9,32'h2, 0,0, 9,0,
                    BYP ? 32'h2 : 32'h0, 0, BYP ? 2'b00 : 2'b01, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  9,0, 32'h2,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0, 0,0, 2'b00, 0));
    vt.push_back(mk(1,10,32'h5, 0,0,0, 1,10, 10,0,
                    BYP ? 32'h5 : 32'h0, 0, BYP ? 2'b00 : 2'b01, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  10,0, 32'h5,0, 2'b01, 0));
    vt.push_back(mk(1,10,32'h6, 0,0,0, 0,0, 10,0,
                    BYP ? 32'h6 : 32'h5, 0, BYP ? 2'b00 : 2'b01, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  10,0, 32'h6,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,3,  0,0, 0,0, 2'b00, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 1,3,  3,0, 0,0, 2'b01, 0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  3,0, 0,0, 2'b01, 1));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0, 0,0, 2'b00, 1));

    @(negedge clk);
    clrn = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rn = {AW'(2*a+1), AW'(2*a)};
      #1;
      chk($sformatf("rst_q_rn%0d", 2*a), {q, rbusy, err}, '0);
    end

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i]);
      #2;
      chk($sformatf("v%0d_q0", i),    q[DW-1:0],  vt[i].eq0);
      chk($sformatf("v%0d_q1", i),    q[2*DW-1:DW], vt[i].eq1);
      chk($sformatf("v%0d_rbusy", i), rbusy,      vt[i].ebusy);
      chk($sformatf("v%0d_err", i),   err,        vt[i].eerr);
    end

    // Asynchronous reset between edges clears q at once; writes held during reset are ignored.
    @(negedge clk);
    idle(); rn = {AW'(0), AW'(9)};
    #1 chk("pre_rst_q9", q[DW-1:0], 32'h2);
    @(posedge clk);
    #2 clrn = 1'b1;
    #1 chk("async_rst_q9", q[DW-1:0], 32'h0);
    chk("async_rst_err", err, 1'b0);
    @(negedge clk);
    wea = 1'b1; wna = 5'd12; da = 32'h77; rn = {AW'(0), AW'(12)};
    #1 chk("rst_hold_q12", q[DW-1:0], 32'h0);
    @(negedge clk);
    idle(); clrn = 1'b0;
    #1 chk("rst_write_ignored", q[DW-1:0], 32'h0);
    chk("rst_write_err", err, 1'b0);

    // Write to a register that was never issued.
    @(negedge clk);
    wea = 1'b1; wna = 5'd4; da = 32'h44;
    @(negedge clk);
    idle(); rn = {AW'(0), AW'(4)};
    #1 chk("unissued_wr_err", err, 1'b1);
    chk("unissued_wr_q4", q[DW-1:0], 32'h44);

    // Reset between issue and writeback drops the pending producer.
    @(negedge clk); clrn = 1'b1;
    @(negedge clk); clrn = 1'b0; iss = 1'b1; iss_wn = 5'd6;
    @(negedge clk); idle(); rn = {AW'(0), AW'(6)};
    #1 chk("iss6_busy", rbusy, 2'b01);
    chk("iss6_err", err, 1'b0);
    @(negedge clk); clrn = 1'b1;
    @(negedge clk); clrn = 1'b0;
    #1 chk("rst_drop_busy6", rbusy, 2'b00);
    chk("rst_drop_err", err, 1'b0);
    wea = 1'b1; wna = 5'd6; da = 32'h66;
    @(negedge clk);
    idle();
    #1 chk("late_wr_err", err, 1'b1);
    chk("late_wr_q6", q[DW-1:0], 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file for the pipelined CPU datapath: NR read ports, two write ports (ALU writeback A, load writeback B), register 0 hardwired to zero.
Adds a per-register scoreboard (busy bits) so decode can stall on pending producers.
Sits between decode (reads, issue) and writeback (writes).

Parameters:
DW, 32, data width of each register
AW, 5, address width; depth = 2**AW registers, index 0 is constant zero
NR, 2, number of read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
clrn  input  1  reset, asynchronous, active-high; clears all registers, busy bits and err
rn  input  NR*AW  read addresses, port k at bits [k*AW +: AW]
q  output  NR*DW  read data, port k at bits [k*DW +: DW]
rbusy  output  NR  port k addresses a register with a pending producer
wea  input  1  write enable, port A
wna  input  AW  write address, port A
da  input  DW  write data, port A
web  input  1  write enable, port B
wnb  input  AW  write address, port B
db  input  DW  write data, port B
iss  input  1  issue: mark register iss_wn busy
iss_wn  input  AW  destination register of the issuing instruction
err  output  1  sticky: issue to an already-busy register, or a write to a non-busy register

Behaviour:
- Reset (clrn=1, asynchronous, active-high; clock clk): all registers 0, all busy bits 0, err 0. While clrn=1, writes and issues are ignored. Resulting outputs: q = 0, rbusy = 0.
- Read: q[k] is combinational from rn[k]. rn[k]=0 returns 0 and rbusy[k]=0 regardless of other inputs.
- Write: at the rising edge, if we* is set and wn* != 0, reg[wn*] <= d*. Writes to register 0 are dropped and do not affect err.
- Write collision: wea and web set with wna=wnb != 0 gives port B priority; reg gets db.
- Busy bits, per register r != 0, evaluated at the rising edge:
  - Set when iss=1 and iss_wn=r.
  - Cleared when a write (A or B) targets r.
  - Issue and write to r in the same cycle: busy stays 1, because the new producer wins.
  - iss_wn=0: no effect.
- Scoreboard rule: one outstanding producer per register.
  - err <= 1 when iss targets a register that is busy and not being written in the same cycle.
  - err <= 1 when a write targets a register r != 0 whose busy bit is 0.
  - err clears only on reset.
- rbusy[k] = busy[rn[k]] AND NOT (a write to rn[k] this cycle). Under RF_BYPASS_EN this lets decode proceed with the forwarded value.
- Latency: a write is visible through the register array one cycle after the edge. Bypass timing is given under Optional Feature.
- Reset mid-operation: clrn asserted between issue and writeback drops all pending busy bits. A later write to that register then sets err.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: a read of rn[k] matching an enabled write this cycle returns the write data combinationally (port B data if both ports match). rbusy[k] is masked as above.
- Undefined: q reflects stored contents only, so same-cycle write data appears on the next cycle. rbusy[k] = busy[rn[k]] with no same-cycle write masking.

Decomposition:
- Package regfile_pkg: DW/AW default constants, reg-index typedef (logic [AW-1:0]), ZERO_REG constant.
- One sub-module, rf_scoreboard: holds the busy vector and err, with inputs iss/iss_wn/wea/wna/web/wnb and outputs busy vector and err.
- regfile_mp_sb holds the storage array, write priority, the read muxes and bypass, and instantiates rf_scoreboard.

Test Plan:
- Reset then read all ports, rn=0..31 -> q=0, rbusy=0, err=0. Write reg0 with 32'hFFFF_FFFF -> q stays 0 for rn=0, err stays 0.
- iss=1 iss_wn=5, next cycle rn[0]=5 -> rbusy[0]=1. Then wea=1 wna=5 da=32'h1234 -> with RF_BYPASS_EN q[0]=32'h1234 and rbusy[0]=0 in the same cycle. Next cycle busy clear, q=32'h1234.
- iss_wn=7 and iss_wn=8, then wea wna=7 da=32'hA, web wnb=8 db=32'hB in the same cycle -> reg7=A, reg8=B, both busy cleared, err=0.
- Port collision: iss 9, then wea/web both to 9 with da=1, db=2 -> reg9=2, err=0.
- iss 3, then iss 3 again with no write -> err=1 and stays 1. Write reg 4 without an issue (fresh reset) -> err=1.
- iss 6, assert clrn for one cycle, then wea wna=6 -> busy6=0 after reset, err=1. Assert clrn mid-cycle between edges -> q drops to 0 immediately, without waiting for a clock edge.
